// File: rtl/fpu_wb_arbiter_if.sv
// Bus between the FPU result channels and the register-file write-back arbiter.
// The master drives per-channel results; the slave (arbiter) drives the write ports.
interface fpu_wb_arbiter_if #(
    parameter int NCH = 14
);
    logic [NCH-1:0]    res_valid;
    logic [5*NCH-1:0]  res_rt;
    logic [32*NCH-1:0] res_data;
    logic              wb0_en;
    logic [4:0]        wb0_rt;
    logic [31:0]       wb0_data;
    logic              wb1_en;
    logic [4:0]        wb1_rt;
    logic [31:0]       wb1_data;
    logic              fpu_stall;
    logic              ovf;

    modport master (
        output res_valid, res_rt, res_data,
        input  wb0_en, wb0_rt, wb0_data, wb1_en, wb1_rt, wb1_data, fpu_stall, ovf
    );

    modport slave (
        input  res_valid, res_rt, res_data,
        output wb0_en, wb0_rt, wb0_data, wb1_en, wb1_rt, wb1_data, fpu_stall, ovf
    );
endinterface

// File: rtl/fpu_wb_arbiter.sv
// Buffers FPU unit results per channel and retires up to two per cycle onto the
// register-file write ports with round-robin fairness and a stall request to issue.
module fpu_wb_arbiter #(
    parameter int NCH      = 14,
    parameter int QDEPTH   = 2,
    parameter int STALL_TH = 4
) (
    input logic           clk,
    input logic           rstn,
    fpu_wb_arbiter_if.slave bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = $clog2(NCH * QDEPTH + 1);

    logic [4:0]    rt_q   [NCH][QDEPTH];
    logic [31:0]   data_q [NCH][QDEPTH];
    logic [PW-1:0] head_q [NCH];
    logic [PW-1:0] head_d [NCH];
    logic [PW-1:0] tail_q [NCH];
    logic [PW-1:0] tail_d [NCH];
    logic [CW-1:0] cnt_q  [NCH];
    logic [CW-1:0] cnt_d  [NCH];
    logic [IW-1:0] rr_q, rr_d;
    logic          ovf_q, ovf_d;

    logic [NCH-1:0] push_s, pop_s, drop_s;
    logic           g0_v_s, g1_v_s;
    logic [IW-1:0]  g0_idx_s, g1_idx_s, idx_s;
    logic [4:0]     g0_rt_s, g1_rt_s;
    logic [31:0]    g0_data_s, g1_data_s;
    logic [SW-1:0]  sum_s;

    logic        wb0_en_q, wb1_en_q;
    logic [4:0]  wb0_rt_q, wb1_rt_q;
    logic [31:0] wb0_data_q, wb1_data_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    function automatic logic [IW-1:0] ch_wrap(input int v);
        if (v >= NCH) begin
            return IW'(v - NCH);
        end else begin
            return IW'(v);
        end
    endfunction

    // Round-robin scan: first non-empty channel to port 0, next one with a different rt to port 1.
    always_comb begin
        g0_v_s    = 1'b0;
        g1_v_s    = 1'b0;
        g0_idx_s  = {IW{1'b0}};
        g1_idx_s  = {IW{1'b0}};
        g0_rt_s   = 5'd0;
        g1_rt_s   = 5'd0;
        g0_data_s = 32'd0;
        g1_data_s = 32'd0;
        idx_s     = {IW{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            idx_s = ch_wrap(int'(rr_q) + k);
            if (cnt_q[idx_s] != {CW{1'b0}}) begin
                if (!g0_v_s) begin
                    g0_v_s    = 1'b1;
                    g0_idx_s  = idx_s;
                    g0_rt_s   = rt_q[idx_s][head_q[idx_s]];
                    g0_data_s = data_q[idx_s][head_q[idx_s]];
                end else if (!g1_v_s && (rt_q[idx_s][head_q[idx_s]] != g0_rt_s)) begin
                    g1_v_s    = 1'b1;
                    g1_idx_s  = idx_s;
                    g1_rt_s   = rt_q[idx_s][head_q[idx_s]];
                    g1_data_s = data_q[idx_s][head_q[idx_s]];
                end else begin
                    g1_v_s = g1_v_s;
                end
            end else begin
                idx_s = idx_s;
            end
        end
        if (g1_v_s) begin
            rr_d = ch_wrap(int'(g1_idx_s) + 1);
        end else if (g0_v_s) begin
            rr_d = ch_wrap(int'(g0_idx_s) + 1);
        end else begin
            rr_d = rr_q;
        end
    end

    // Per-channel push/pop decisions and FIFO pointer/count next state.
    always_comb begin
        push_s = {NCH{1'b0}};
        pop_s  = {NCH{1'b0}};
        drop_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            pop_s[i]  = (g0_v_s && (g0_idx_s == IW'(i))) || (g1_v_s && (g1_idx_s == IW'(i)));
            // A full channel still accepts when its head leaves in the same cycle.
            push_s[i] = bus.res_valid[i] && ((cnt_q[i] != CW'(QDEPTH)) || pop_s[i]);
            drop_s[i] = bus.res_valid[i] && (cnt_q[i] == CW'(QDEPTH)) && !pop_s[i];
            head_d[i] = pop_s[i]  ? ptr_inc(head_q[i]) : head_q[i];
            tail_d[i] = push_s[i] ? ptr_inc(tail_q[i]) : tail_q[i];
            if (push_s[i] && !pop_s[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (pop_s[i] && !push_s[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
        ovf_d = ovf_q | (|drop_s);
    end

    // Total occupancy drives the issue stall request.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            sum_s = sum_s + SW'(cnt_q[i]);
        end
    end

    // Control state: pointers, counts, round-robin pointer, sticky overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                head_q[i] <= {PW{1'b0}};
                tail_q[i] <= {PW{1'b0}};
                cnt_q[i]  <= {CW{1'b0}};
            end
            rr_q  <= {IW{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            rr_q  <= rr_d;
            ovf_q <= ovf_d;
        end
    end

    // Queue storage; contents are only meaningful below the count, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rstn && push_s[i]) begin
                rt_q[i][tail_q[i]]   <= bus.res_rt[5*i +: 5];
                data_q[i][tail_q[i]] <= bus.res_data[32*i +: 32];
            end
        end
    end

    // Registered write ports.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb0_en_q   <= 1'b0;
            wb0_rt_q   <= 5'd0;
            wb0_data_q <= 32'd0;
            wb1_en_q   <= 1'b0;
            wb1_rt_q   <= 5'd0;
            wb1_data_q <= 32'd0;
        end else begin
            wb0_en_q   <= g0_v_s;
            wb0_rt_q   <= g0_rt_s;
            wb0_data_q <= g0_data_s;
            wb1_en_q   <= g1_v_s;
            wb1_rt_q   <= g1_rt_s;
            wb1_data_q <= g1_data_s;
        end
    end

    assign bus.wb0_en    = wb0_en_q;
    assign bus.wb0_rt    = wb0_rt_q;
    assign bus.wb0_data  = wb0_data_q;
    assign bus.wb1_en    = wb1_en_q;
    assign bus.wb1_rt    = wb1_rt_q;
    assign bus.wb1_data  = wb1_data_q;
    assign bus.fpu_stall = (sum_s >= SW'(STALL_TH));
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed self-checking bench for fpu_wb_arbiter with hand-computed expectations.
module tb_fpu_wb_arbiter;
    localparam int NCH = 14;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    fpu_wb_arbiter_if #(.NCH(NCH)) bus ();

    fpu_wb_arbiter #(.NCH(NCH), .QDEPTH(2), .STALL_TH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.res_valid = '0;
        bus.res_rt    = '0;
        bus.res_data  = '0;
    endtask

    task automatic put(input int ch, input logic [4:0] rt, input logic [31:0] d);
        bus.res_valid[ch]       = 1'b1;
        bus.res_rt[5*ch +: 5]   = rt;
        bus.res_data[32*ch +: 32] = d;
    endtask

    task automatic unput(input int ch);
        bus.res_valid[ch] = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clr();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        bit seen5;
        bit seen13;
        int n30;
        int nall;
        int nd3;
        int nstale;
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        clr();
        tick();
        tick();

        // reset state
        chk("rst_wb0_en", {31'd0, bus.wb0_en}, 32'd0);
        chk("rst_wb1_en", {31'd0, bus.wb1_en}, 32'd0);
        chk("rst_wb0_rt", {27'd0, bus.wb0_rt}, 32'd0);
        chk("rst_wb1_data", bus.wb1_data, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rst_stall", {31'd0, bus.fpu_stall}, 32'd0);
        rstn = 1'b1;

        // single result on ch 4
        put(4, 5'd7, 32'h3F80_0000);
        tick();
        clr();
        chk("single_stall_c1", {31'd0, bus.fpu_stall}, 32'd0);
        chk("single_en_c1", {31'd0, bus.wb0_en}, 32'd0);
        tick();
        chk("single_wb0_en", {31'd0, bus.wb0_en}, 32'd1);
        chk("single_wb0_rt", {27'd0, bus.wb0_rt}, 32'd7);
        chk("single_wb0_data", bus.wb0_data, 32'h3F80_0000);
        chk("single_wb1_en", {31'd0, bus.wb1_en}, 32'd0);
        chk("single_stall_c2", {31'd0, bus.fpu_stall}, 32'd0);
        tick();
        chk("single_idle_en", {31'd0, bus.wb0_en}, 32'd0);

        // burst on ch 0,1,2 from rr_ptr 0
        do_reset();
        put(0, 5'd1, 32'h0000_0100);
        put(1, 5'd2, 32'h0000_0200);
        put(2, 5'd3, 32'h0000_0300);
        tick();
        clr();
        tick();
        chk("burst_c2_wb0_en", {31'd0, bus.wb0_en}, 32'd1);
        chk("burst_c2_wb0_rt", {27'd0, bus.wb0_rt}, 32'd1);
        chk("burst_c2_wb0_data", bus.wb0_data, 32'h0000_0100);
        chk("burst_c2_wb1_en", {31'd0, bus.wb1_en}, 32'd1);
        chk("burst_c2_wb1_rt", {27'd0, bus.wb1_rt}, 32'd2);
        chk("burst_c2_wb1_data", bus.wb1_data, 32'h0000_0200);
        tick();
        chk("burst_c3_wb0_en", {31'd0, bus.wb0_en}, 32'd1);
        chk("burst_c3_wb0_rt", {27'd0, bus.wb0_rt}, 32'd3);
        chk("burst_c3_wb1_en", {31'd0, bus.wb1_en}, 32'd0);
        chk("burst_rr_ptr", 32'(dut.rr_q), 32'd3);

        // rt conflict between ch 2 and ch 3
        do_reset();
        put(2, 5'd9, 32'h0000_AAAA);
        put(3, 5'd9, 32'h0000_BBBB);
        tick();
        clr();
        tick();
        chk("conf_c2_wb0_en", {31'd0, bus.wb0_en}, 32'd1);
        chk("conf_c2_wb0_data", bus.wb0_data, 32'h0000_AAAA);
        chk("conf_c2_wb1_en", {31'd0, bus.wb1_en}, 32'd0);
        tick();
        chk("conf_c3_wb0_en", {31'd0, bus.wb0_en}, 32'd1);
        chk("conf_c3_wb0_rt", {27'd0, bus.wb0_rt}, 32'd9);
        chk("conf_c3_wb0_data", bus.wb0_data, 32'h0000_BBBB);
        chk("conf_c3_wb1_en", {31'd0, bus.wb1_en}, 32'd0);

        // fairness: ch 0 and ch 13 refilled each cycle, ch 5 holds one entry
        do_reset();
        seen5  = 1'b0;
        seen13 = 1'b0;
        put(0, 5'd10, 32'h0000_0010);
        put(5, 5'd5, 32'h0000_0005);
        put(13, 5'd20, 32'h0000_0020);
        for (int i = 0; i < 8; i++) begin
            tick();
            unput(5);
            if ((bus.wb0_en && bus.wb0_rt == 5'd5) || (bus.wb1_en && bus.wb1_rt == 5'd5)) seen5 = 1'b1;
            if ((bus.wb0_en && bus.wb0_rt == 5'd20) || (bus.wb1_en && bus.wb1_rt == 5'd20)) seen13 = 1'b1;
        end
        clr();
        chk("fair_ch5_retired", {31'd0, seen5}, 32'd1);
        chk("fair_ch13_retired", {31'd0, seen13}, 32'd1);

        // stall: 5 channels valid in one cycle
        do_reset();
        for (int c = 0; c < 5; c++) put(c, 5'(c + 1), 32'(c));
        tick();
        clr();
        chk("stall_5ch", {31'd0, bus.fpu_stall}, 32'd1);
        chk("stall_no_ovf", {31'd0, bus.ovf}, 32'd0);

        // overflow: ch 6 valid for three cycles while ch 0..5 hold entries
        do_reset();
        n30  = 0;
        nall = 0;
        nd3  = 0;
        for (int c = 0; c < 6; c++) put(c, 5'(c + 1), 32'(c + 16));
        put(6, 5'd30, 32'hD000_0001);
        tick();
        clr();
        put(6, 5'd30, 32'hD000_0002);
        tick();
        chk("ovf_before_drop", {31'd0, bus.ovf}, 32'd0);
        nall += int'(bus.wb0_en) + int'(bus.wb1_en);
        put(6, 5'd30, 32'hD000_0003);
        tick();
        clr();
        chk("ovf_set", {31'd0, bus.ovf}, 32'd1);
        nall += int'(bus.wb0_en) + int'(bus.wb1_en);
        for (int i = 0; i < 10; i++) begin
            tick();
            nall += int'(bus.wb0_en) + int'(bus.wb1_en);
            if (bus.wb0_en && bus.wb0_rt == 5'd30) n30++;
            if (bus.wb1_en && bus.wb1_rt == 5'd30) n30++;
            if ((bus.wb0_en && bus.wb0_data == 32'hD000_0003) ||
                (bus.wb1_en && bus.wb1_data == 32'hD000_0003)) nd3++;
        end
        chk("ovf_sticky", {31'd0, bus.ovf}, 32'd1);
        chk("ovf_ch6_retired", 32'(n30), 32'd2);
        chk("ovf_dropped_absent", 32'(nd3), 32'd0);
        chk("ovf_total_retired", 32'(nall), 32'd8);

        // reset mid-burst with 6 entries queued
        do_reset();
        for (int c = 0; c < 6; c++) put(c, 5'(c + 1), 32'(c + 32));
        tick();
        clr();
        chk("rmid_stall_pre", {31'd0, bus.fpu_stall}, 32'd1);
        rstn = 1'b0;
        put(7, 5'd17, 32'h0000_0777);
        tick();
        chk("rmid_wb0_en", {31'd0, bus.wb0_en}, 32'd0);
        chk("rmid_wb1_en", {31'd0, bus.wb1_en}, 32'd0);
        chk("rmid_stall", {31'd0, bus.fpu_stall}, 32'd0);
        chk("rmid_ovf", {31'd0, bus.ovf}, 32'd0);
        rstn = 1'b1;
        clr();
        nstale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nstale += int'(bus.wb0_en) + int'(bus.wb1_en);
        end
        chk("rmid_no_stale", 32'(nstale), 32'd0);
        chk("rmid_stall_post", {31'd0, bus.fpu_stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_wb_arbiter.md
# fpu_wb_arbiter

Collects completed results from the per-lane FPU units (fadd, fsub, fmul, fdiv, fsqrt, ftoi, itof; upper and lower lane) and retires them onto the two FPU register-file write ports. The FPU units have fixed, unequal latencies and no back-pressure, so several results can complete in the same cycle. This block buffers each unit's results, arbitrates round-robin, and raises a stall request toward issue when buffering runs low. It is the receiving end of the operand/rt/rt_flag path the execute stage drives into the FPUs.

## Interface
- NCH, 14, number of FPU result channels; channel index = 2*op + lane, with lane 0 = upper and 1 = lower, op order fadd..itof
- QDEPTH, 2, per-channel queue depth, power of two
- STALL_TH, 4, total pending entries at or above which fpu_stall asserts
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- res_valid  in  NCH  per-channel result valid (the unit's rt_flag output)
- res_rt  in  5*NCH  destination register; channel i in bits [5i+4:5i]
- res_data  in  32*NCH  result data; channel i in bits [32i+31:32i]
- wb0_en / wb1_en  out  1  write-port enable
- wb0_rt / wb1_rt  out  5  write-port destination
- wb0_data / wb1_data  out  32  write-port data
- fpu_stall  out  1  issue must not launch new FPU ops
- ovf  out  1  sticky overflow error flag

## Operation
- Each channel has a FIFO of QDEPTH entries {rt, data}, with head/tail pointers and a count. A valid result is enqueued at the clock edge.
- Grant: scan the channels in order rr_ptr, rr_ptr+1, ... mod NCH, over channels whose count is nonzero at the start of the cycle.
  - The first hit goes to port 0.
  - The next hit with rt different from port 0's rt goes to port 1.
  - A hit with the same rt is skipped and stays queued.
  - A granted channel pops exactly one entry.
- rr_ptr moves to (last granted index + 1) mod NCH. It is unchanged when nothing is granted.
- Results leave each channel in arrival order. No ordering is guaranteed across channels.
- Enqueue and dequeue on the same channel in the same cycle are both legal. The count is unchanged, and the new entry is not grantable until the next cycle.
- Enqueue to a full channel with no pop that cycle: the entry is dropped, ovf is set to 1 and stays 1 until reset. Other channels are unaffected.
- fpu_stall = (sum of all channel counts ≥ STALL_TH). It is combinational from registered counts.
- Reset: all counts, pointers and rr_ptr are cleared to 0.

## Timing
- Reset values: wb0_en = wb1_en = 0, wb0_rt = wb1_rt = 0, wb0_data = wb1_data = 0, ovf = 0, fpu_stall = 0.
- All wb* outputs are registered.
- A result valid in cycle t shows up on a write port at the earliest in cycle t+2: enqueued at edge t, granted in cycle t+1, wb* registered at edge t+1.
- Throughput is at most 2 retirements per cycle. A single channel retires at most 1 per cycle.
- The wb*_en of a port with no grant is 0 in the next cycle. Its rt and data are don't-care.
- fpu_stall changes in the same cycle the counts change (edge t). Issue sees it in cycle t+1.
- Reset during operation discards all queued results. Outputs take their reset values at the next edge, and inputs valid in the reset cycle are ignored.

## Test plan
- Single result: ch 4 (fmul upper), rt = 7, data = 0x3F800000 in cycle 0 -> wb0_en = 1, rt 7, data 0x3F800000 in cycle 2; wb1_en = 0; fpu_stall never asserts.
- Burst: ch 0, 1, 2 valid in cycle 0 (rt 1, 2, 3) with rr_ptr = 0 -> cycle 2 retires rt 1 (port 0) and rt 2 (port 1); cycle 3 retires rt 3 (port 0); rr_ptr ends at 3.
- Fairness: ch 0 and ch 13 refilled every cycle while ch 5 holds one entry -> ch 5 retires within 7 cycles; no channel is starved.
- rt conflict: ch 2 and ch 3 both have rt = 9 -> only ch 2 retires in the first cycle; ch 3 retires in the following cycle on port 0.
- Stall and overflow (STALL_TH = 4): 5 channels valid in one cycle -> fpu_stall = 1 the next cycle. Ch 6 valid for 3 consecutive cycles while ch 0..5 also hold entries -> third ch 6 entry dropped, ovf = 1 and sticky.
- Reset mid-burst: rstn low with 6 entries queued -> next cycle wb0_en = wb1_en = 0 and fpu_stall = 0; after release, no stale result ever retires.
